// File: rtl/sd_cmd_sender_pkg.sv
// sd_cmd_sender_pkg: shared states, SPI-mode SD command frame constants and sizing helper
package sd_cmd_sender_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SEND, WAIT_RESP, RECV, DONE} state_t;
  localparam int FRAME_LEN = 48;
  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [7:0] R1_IDLE = 8'h01;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/sd_frame_shifter.sv
// sd_frame_shifter: 48-bit MSB-first command frame shift register with bit counter
module sd_frame_shifter
  import sd_cmd_sender_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [FRAME_LEN-1:0] data,
  output logic                 bit_out,
  output logic                 done
);
  logic [FRAME_LEN-1:0] sr;
  logic [5:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= data;
      cnt <= '0;
    end else if (shift) begin
      sr <= {sr[FRAME_LEN-2:0], 1'b1};
      cnt <= cnt + 6'd1;
    end
  assign bit_out = sr[FRAME_LEN-1];
  // high while the final frame bit is on the wire
  assign done = cnt == 6'(FRAME_LEN - 1);
endmodule

// File: rtl/sd_cmd_sender.sv
// sd_cmd_sender: sends one SPI-mode SD command frame and captures the R1 response byte
module sd_cmd_sender
  import sd_cmd_sender_pkg::*;
#(
  parameter int PRE_BITS = 8,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_START,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  input  logic [6:0]  CMD_CRC,
  input  logic        DO,
  output logic        DI,
  output logic        CS_N,
  output logic [7:0]  RESP,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic        CMD_TIMEOUT
);
  localparam int CW = $clog2(max3(PRE_BITS, FRAME_LEN, RESP_TIMEOUT) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] resp;
  logic timeout, sh_bit, sh_done;
  sd_frame_shifter u_shifter (
    .clk(CLK),
    .rst(RESET),
    .load(state == IDLE && CMD_START),
    .shift(state == SEND),
    .data({START_BITS, CMD_INDEX, CMD_ARG, CMD_CRC, STOP_BIT}),
    .bit_out(sh_bit),
    .done(sh_done)
  );
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      resp <= 8'hFF;
      timeout <= 1'b0;
    end else
      case (state)
        IDLE: if (CMD_START) begin
          state <= PRE;
          cnt <= '0;
          timeout <= 1'b0;
        end
        PRE: if (cnt == CW'(PRE_BITS - 1)) begin
          state <= SEND;
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
        SEND: if (sh_done) state <= WAIT_RESP;
        // the first low DO sample is the R1 start bit and becomes RESP[7]
        WAIT_RESP: if (!DO) begin
          resp <= {resp[6:0], 1'b0};
          state <= RECV;
          cnt <= '0;
        end else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
          resp <= 8'hFF;
          timeout <= 1'b1;
          state <= DONE;
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
        RECV: begin
          resp <= {resp[6:0], DO};
          if (cnt == CW'(6)) begin
            state <= DONE;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        end
        DONE: if (!CMD_START) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign DI = state == SEND ? sh_bit : 1'b1;
  assign CS_N = state == IDLE;
  assign CMD_BUSY = state inside {PRE, SEND, WAIT_RESP, RECV};
  assign CMD_DONE = state == DONE;
  assign CMD_TIMEOUT = timeout;
  assign RESP = resp;
endmodule

// File: tb/tb_sd_cmd_sender.sv
// tb_sd_cmd_sender: directed checks of frame timing, R1 capture, timeout, reset and hold behaviour
module tb_sd_cmd_sender;
  logic CLK = 0, RESET = 1, CMD_START = 0, DO = 1;
  logic [5:0] CMD_INDEX = '0;
  logic [31:0] CMD_ARG = '0;
  logic [6:0] CMD_CRC = '0;
  logic DI, CS_N, CMD_BUSY, CMD_DONE, CMD_TIMEOUT;
  logic [7:0] RESP;
  int tests = 0, fails = 0;

  sd_cmd_sender dut (
    .CLK(CLK), .RESET(RESET), .CMD_START(CMD_START), .CMD_INDEX(CMD_INDEX),
    .CMD_ARG(CMD_ARG), .CMD_CRC(CMD_CRC), .DO(DO), .DI(DI), .CS_N(CS_N),
    .RESP(RESP), .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_TIMEOUT(CMD_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // accepts a command, records PRE behaviour and the 48 DI bits, then plays the card response
  task automatic capture(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input int idle, input logic [7:0] r, input bit respond, input bit mutate,
                         output logic [47:0] frame, output int lat, output bit pre_ok);
    CMD_INDEX = idx; CMD_ARG = arg; CMD_CRC = crc; CMD_START = 1; DO = 1;
    step();
    pre_ok = 1;
    for (int i = 0; i < 8; i++) begin
      if (DI !== 1'b1 || CS_N !== 1'b0 || CMD_BUSY !== 1'b1) pre_ok = 0;
      step();
    end
    frame = '0;
    for (int i = 0; i < 48; i++) begin
      frame = {frame[46:0], DI};
      if (mutate && i == 10) begin CMD_ARG = ~arg; CMD_INDEX = ~idx; CMD_CRC = ~crc; end
      step();
    end
    lat = -1;
    for (int j = 0; j < 200 && lat < 0; j++) begin
      DO = (respond && j >= idle && j < idle + 8) ? r[7 - (j - idle)] : 1'b1;
      step();
      if (CMD_DONE === 1'b1) lat = j + 1;
    end
    DO = 1;
  endtask

  task automatic test_reset();
    RESET = 1; CMD_START = 1;
    step(); step();
    tests++; if (DI !== 1'b1) begin fails++; $display("FAIL reset_di got %b exp 1", DI); end
    tests++; if (CS_N !== 1'b1) begin fails++; $display("FAIL reset_cs_n got %b exp 1", CS_N); end
    tests++; if (RESP !== 8'hFF) begin fails++; $display("FAIL reset_resp got %h exp ff", RESP); end
    tests++; if (CMD_BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", CMD_BUSY); end
    tests++; if (CMD_DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", CMD_DONE); end
    tests++; if (CMD_TIMEOUT !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", CMD_TIMEOUT); end
    RESET = 0; CMD_START = 0;
    step();
  endtask

  task automatic test_cmd0();
    logic [47:0] f; int lat; bit pre_ok;
    capture(6'd0, 32'h0, 7'h4A, 3, 8'h01, 1, 0, f, lat, pre_ok);
    tests++; if (!pre_ok) begin fails++; $display("FAIL cmd0_pre got bad PRE phase exp DI=1 CS_N=0 BUSY=1"); end
    tests++; if (f !== 48'h400000000095) begin fails++; $display("FAIL cmd0_frame got %h exp 400000000095", f); end
    tests++; if (lat != 11) begin fails++; $display("FAIL cmd0_latency got %0d exp 11", lat); end
    tests++; if (RESP !== 8'h01) begin fails++; $display("FAIL cmd0_resp got %h exp 01", RESP); end
    tests++; if (CMD_TIMEOUT !== 1'b0) begin fails++; $display("FAIL cmd0_timeout got %b exp 0", CMD_TIMEOUT); end
    tests++; if (CMD_BUSY !== 1'b0 || CS_N !== 1'b0 || DI !== 1'b1) begin
      fails++; $display("FAIL cmd0_done_pins got busy=%b cs_n=%b di=%b exp 0 0 1", CMD_BUSY, CS_N, DI); end
    CMD_START = 0;
    step();
    tests++; if (CMD_DONE !== 1'b0 || CS_N !== 1'b1) begin
      fails++; $display("FAIL cmd0_exit got done=%b cs_n=%b exp 0 1", CMD_DONE, CS_N); end
  endtask

  task automatic test_cmd24_zero_wait();
    logic [47:0] f; int lat; bit pre_ok;
    capture(6'd24, 32'h00000200, 7'h7F, 0, 8'h00, 1, 0, f, lat, pre_ok);
    tests++; if (f !== 48'h5800000200FF) begin fails++; $display("FAIL cmd24_frame got %h exp 5800000200ff", f); end
    tests++; if (lat != 8) begin fails++; $display("FAIL cmd24_latency got %0d exp 8", lat); end
    tests++; if (RESP !== 8'h00 || CMD_TIMEOUT !== 1'b0) begin
      fails++; $display("FAIL cmd24_resp got %h to=%b exp 00 0", RESP, CMD_TIMEOUT); end
    CMD_START = 0;
    step();
  endtask

  task automatic test_timeout();
    logic [47:0] f; int lat; bit pre_ok;
    capture(6'd17, 32'h12345678, 7'h2B, 0, 8'h00, 0, 0, f, lat, pre_ok);
    tests++; if (f !== 48'h5112345678_57) begin fails++; $display("FAIL to_frame got %h exp 511234567857", f); end
    tests++; if (lat != 64) begin fails++; $display("FAIL to_latency got %0d exp 64", lat); end
    tests++; if (RESP !== 8'hFF || CMD_TIMEOUT !== 1'b1) begin
      fails++; $display("FAIL to_flags got resp=%h to=%b exp ff 1", RESP, CMD_TIMEOUT); end
    CMD_START = 0;
    step();
  endtask

  task automatic test_reset_mid_send();
    logic [47:0] f; int lat; bit pre_ok; bit quiet;
    CMD_INDEX = 6'd0; CMD_ARG = 32'hFFFFFFFF; CMD_CRC = 7'h00; CMD_START = 1;
    step();
    CMD_START = 0;
    for (int i = 0; i < 8 + 20; i++) step();
    tests++; if (DI !== 1'b1 || CS_N !== 1'b0) begin
      fails++; $display("FAIL mid_bit20 got di=%b cs_n=%b exp 1 0", DI, CS_N); end
    RESET = 1;
    step();
    RESET = 0;
    tests++; if (DI !== 1'b1 || CS_N !== 1'b1 || CMD_BUSY !== 1'b0) begin
      fails++; $display("FAIL mid_abort got di=%b cs_n=%b busy=%b exp 1 1 0", DI, CS_N, CMD_BUSY); end
    quiet = 1;
    for (int i = 0; i < 40; i++) begin if (DI !== 1'b1 || CS_N !== 1'b1) quiet = 0; step(); end
    tests++; if (!quiet) begin fails++; $display("FAIL mid_quiet got frame activity after reset exp idle"); end
    capture(6'd0, 32'h0, 7'h4A, 1, 8'h05, 1, 0, f, lat, pre_ok);
    tests++; if (f !== 48'h400000000095 || !pre_ok) begin
      fails++; $display("FAIL mid_clean_frame got %h pre_ok=%b exp 400000000095 1", f, pre_ok); end
    tests++; if (RESP !== 8'h05 || lat != 9) begin
      fails++; $display("FAIL mid_clean_resp got %h lat=%0d exp 05 9", RESP, lat); end
    CMD_START = 0;
    step();
  endtask

  task automatic test_hold_start();
    logic [47:0] f; int lat; bit pre_ok; bit held;
    capture(6'd24, 32'h00000200, 7'h7F, 2, 8'h00, 1, 1, f, lat, pre_ok);
    tests++; if (f !== 48'h5800000200FF) begin fails++; $display("FAIL hold_frame got %h exp 5800000200ff", f); end
    tests++; if (RESP !== 8'h00 || lat != 10) begin
      fails++; $display("FAIL hold_resp got %h lat=%0d exp 00 10", RESP, lat); end
    held = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (CMD_DONE !== 1'b1 || CMD_BUSY !== 1'b0 || RESP !== 8'h00) held = 0;
    end
    tests++; if (!held) begin fails++; $display("FAIL hold_done got done=%b busy=%b exp 1 0", CMD_DONE, CMD_BUSY); end
    CMD_START = 0;
    step();
    tests++; if (CMD_DONE !== 1'b0 || CMD_BUSY !== 1'b0 || CS_N !== 1'b1) begin
      fails++; $display("FAIL hold_release got done=%b busy=%b cs_n=%b exp 0 0 1", CMD_DONE, CMD_BUSY, CS_N); end
    step();
    tests++; if (CMD_BUSY !== 1'b0 || CS_N !== 1'b1) begin
      fails++; $display("FAIL hold_no_restart got busy=%b cs_n=%b exp 0 1", CMD_BUSY, CS_N); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd24_zero_wait();
    test_timeout();
    test_reset_mid_send();
    test_hold_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_cmd_sender.md
SD_CMD_SENDER -- requirements
Module: sd_cmd_sender

Interface
REQ-001 Parameter PRE_BITS, default 8, number of DI-high cycles before each command frame.
REQ-002 Parameter RESP_TIMEOUT, default 64, maximum wait cycles for the R1 start bit.
REQ-003 CLK  input  1  sole clock; DI driven and DO sampled on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CMD_START  input  1  level request; sampled in IDLE only.
REQ-006 CMD_INDEX  input  6  command index (e.g. 24 for CMD24).
REQ-007 CMD_ARG  input  32  command argument, MSB first.
REQ-008 CMD_CRC  input  7  CRC7 of the command.
REQ-009 DO  input  1  card data out (SPI MISO).
REQ-010 DI  output  1  card data in (SPI MOSI); idle high.
REQ-011 CS_N  output  1  card select, active low.
REQ-012 RESP  output  8  captured R1 byte.
REQ-013 CMD_BUSY  output  1  high from request acceptance until DONE.
REQ-014 CMD_DONE  output  1  completion level.
REQ-015 CMD_TIMEOUT  output  1  no response within RESP_TIMEOUT; valid while CMD_DONE=1.

Function
REQ-016 States: IDLE, PRE, SEND, WAIT_RESP, RECV, DONE.
REQ-017 IDLE: DI=1, CS_N=1, CMD_BUSY=0, CMD_DONE=0; CMD_START=1 at an edge latches CMD_INDEX/ARG/CRC, enters PRE.
REQ-018 Frame = {2'b01, CMD_INDEX, CMD_ARG, CMD_CRC, 1'b1}, 48 bits, transmitted MSB first.
REQ-019 PRE: CS_N=0, DI=1 for exactly PRE_BITS cycles, then SEND.
REQ-020 SEND: one frame bit per cycle for exactly 48 cycles; first DI=0 appears PRE_BITS+1 cycles after acceptance.
REQ-021 WAIT_RESP: DI=1, DO sampled every cycle; first sampled DO=0 is RESP[7], enter RECV.
REQ-022 RECV: 7 further DO samples fill RESP[6:0] MSB first; then DONE with CMD_TIMEOUT=0.
REQ-023 If RESP_TIMEOUT cycles pass in WAIT_RESP with DO=1: RESP=8'hFF, CMD_TIMEOUT=1, enter DONE.
REQ-024 DONE: CMD_DONE=1, CMD_BUSY=0, CS_N=0, DI=1, RESP stable; exit to IDLE on first edge with CMD_START=0.
REQ-025 CMD_START and input changes while busy are ignored; latched frame is used throughout.
REQ-026 DO is sampled synchronously only; no edge-triggered logic on DO.
REQ-027 DO=0 on the very first WAIT_RESP cycle is a valid start bit (zero-wait response).
REQ-028 Internal counters are sized for max(PRE_BITS, 48, RESP_TIMEOUT) without wrap.

Reset
REQ-029 RESET=1 at any edge, any state: next state IDLE, DI=1, CS_N=1, RESP=8'hFF, CMD_BUSY=0, CMD_DONE=0, CMD_TIMEOUT=0, counters 0.
REQ-030 Reset mid-SEND aborts the frame; no further frame bits are driven.
REQ-031 RESET dominates a simultaneous CMD_START.

Structure
REQ-032 Shared package holds: state encodings, FRAME_LEN=48, START_BITS=2'b01, STOP_BIT=1'b1, R1 idle value 8'h01.
REQ-033 One sub-module sd_frame_shifter: 48-bit load/shift register with bit counter and done flag.
REQ-034 sd_cmd_sender feeds the SD data writer: CMD24 completion with RESP=8'h00 precedes that block's WRITE_START.

Verification
REQ-035 CMD0, ARG=0, CRC=7'h4A -> DI carries 48'h400000000095 after 8 high bits; DO=0x01 after 3 idle cycles -> RESP=8'h01, CMD_DONE=1, CMD_TIMEOUT=0.
REQ-036 CMD24, ARG=32'h00000200, CRC=7'h7F -> frame 48'h5800000200FF; DO=0x00 zero-wait -> RESP=8'h00 exactly 8 cycles after frame end.
REQ-037 DO held 1 -> CMD_DONE, CMD_TIMEOUT=1, RESP=8'hFF exactly 64 cycles after frame end.
REQ-038 RESET pulsed at SEND bit 20 -> next edge IDLE, DI=1, CS_N=1; new CMD_START runs a full clean frame.
REQ-039 CMD_START held high through DONE with CMD_ARG changed mid-frame -> frame uses original ARG; no restart until CMD_START drops; CMD_DONE holds until then.
